// File: rtl/serial_code_lock.sv
// serial_code_lock -- serial-entry combination lock with penalty lockout.
//
// A code of CODE_LEN bits is entered MSB first, one bit per cycle on which
// bit_valid is high. The verdict is taken only on the last bit: a correct
// code opens the lock for UNLOCK_CYCLES cycles, a wrong one bumps the
// consecutive-failure count, and reaching MAX_FAILS failures forces a
// LOCKOUT_CYCLES penalty during which all entry is ignored.
//
// Optional feature macro: SERIAL_CODE_LOCK_PROG_EN
//   defined   : code_load while UNLOCKED stores code_in for later attempts
//   undefined : the code is fixed at DEFAULT_CODE; code_in/code_load ignored
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-low reset
//   bit_in     in   serial code bit
//   bit_valid  in   qualifies bit_in
//   code_in    in   [CODE_LEN-1:0] replacement code
//   code_load  in   request to store code_in
//   unlock     out  high while the lock is open
//   locked_out out  high during penalty lockout
//   fail_cnt   out  [3:0] consecutive failed attempts
module serial_code_lock #(
    parameter int                     CODE_LEN       = 6,
    parameter logic [CODE_LEN-1:0]    DEFAULT_CODE   = 6'b111000,
    parameter int                     MAX_FAILS      = 3,
    parameter int                     LOCKOUT_CYCLES = 16,
    parameter int                     UNLOCK_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_in,
    input  logic                bit_valid,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                code_load,
    output logic                unlock,
    output logic                locked_out,
    output logic [3:0]          fail_cnt
);

    localparam int IW   = $clog2(CODE_LEN);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(CODE_LEN - 1);
    localparam logic [3:0]    MAX_F      = 4'(MAX_FAILS);
    localparam logic [TW-1:0] UNLOCK_TOP = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_TOP   = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [IW-1:0]         idx_q,        idx_d;
    logic                  mismatch_q,   mismatch_d;
    logic [3:0]            fail_cnt_q,   fail_cnt_d;
    logic                  unlock_q,     unlock_d;
    logic                  locked_out_q, locked_out_d;
    logic [TW-1:0]         timer_q,      timer_d;
    logic [CODE_LEN-1:0]   code_q,       code_d;

    logic                  mismatch_next_s;
    logic [3:0]            fail_inc_s;

`ifndef SERIAL_CODE_LOCK_PROG_EN
    // The programming ports exist in every build but carry no function here.
    logic unused_prog_s;
    assign unused_prog_s = ^{code_in, code_load};
`endif

    // Next-state and next-output computation for the lock FSM.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        mismatch_d      = mismatch_q;
        fail_cnt_d      = fail_cnt_q;
        unlock_d        = unlock_q;
        locked_out_d    = locked_out_q;
        timer_d         = timer_q;
        code_d          = code_q;
        // Sticky flag including the bit being sampled this cycle.
        mismatch_next_s = mismatch_q | (bit_in != code_q[LAST_IDX - idx_q]);
        fail_inc_s      = fail_cnt_q + 4'd1;

        case (state_q)
            ENTRY: begin
                if (bit_valid) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!mismatch_next_s) begin
                            state_d    = UNLOCKED;
                            fail_cnt_d = 4'd0;
                            unlock_d   = 1'b1;
                            timer_d    = UNLOCK_TOP;
                        end else begin
                            fail_cnt_d = fail_inc_s;
                            if (fail_inc_s == MAX_F) begin
                                state_d      = LOCKOUT;
                                locked_out_d = 1'b1;
                                timer_d      = LOCK_TOP;
                            end else begin
                                state_d = ENTRY;
                            end
                        end
                    end else begin
                        idx_d      = idx_q + {{(IW-1){1'b0}}, 1'b1};
                        mismatch_d = mismatch_next_s;
                    end
                end else begin
                    // Idle cycle: attempt state is simply held, no timeout.
                    state_d = ENTRY;
                end
            end
            UNLOCKED: begin
`ifdef SERIAL_CODE_LOCK_PROG_EN
                if (code_load) begin
                    code_d = code_in;
                end else begin
                    code_d = code_q;
                end
`endif
                // Timer was loaded with N-1, so the lock stays open N cycles.
                if (timer_q == '0) begin
                    state_d  = ENTRY;
                    unlock_d = 1'b0;
                end else begin
                    timer_d = timer_q - {{(TW-1){1'b0}}, 1'b1};
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d      = ENTRY;
                    locked_out_d = 1'b0;
                    fail_cnt_d   = 4'd0;
                end else begin
                    timer_d = timer_q - {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d      = ENTRY;
                idx_d        = '0;
                mismatch_d   = 1'b0;
                fail_cnt_d   = 4'd0;
                unlock_d     = 1'b0;
                locked_out_d = 1'b0;
                timer_d      = '0;
            end
        endcase
    end

    // State and registered-output flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ENTRY;
            idx_q        <= '0;
            mismatch_q   <= 1'b0;
            fail_cnt_q   <= 4'd0;
            unlock_q     <= 1'b0;
            locked_out_q <= 1'b0;
            timer_q      <= '0;
            code_q       <= DEFAULT_CODE;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mismatch_q   <= mismatch_d;
            fail_cnt_q   <= fail_cnt_d;
            unlock_q     <= unlock_d;
            locked_out_q <= locked_out_d;
            timer_q      <= timer_d;
            code_q       <= code_d;
        end
    end

    assign unlock     = unlock_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_serial_code_lock.sv
// Directed testbench for serial_code_lock with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_code_lock;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [5:0] code_in = 6'd0;
    logic       code_load = 1'b0;
    logic       unlock;
    logic       locked_out;
    logic [3:0] fail_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_code_lock dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .code_in    (code_in),
        .code_load  (code_load),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    // Present one valid bit for one cycle; returns at the next falling edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Enter n leading bits (MSB first) of c back to back.
    task automatic send_bits(input logic [5:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_in    = c[5-i];
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Count consecutive sampled cycles with unlock high (bounded).
    task automatic count_unlock(output int n);
        n = 0;
        while (unlock === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (unlock !== 1'b0 || locked_out !== 1'b0 || fail_cnt !== 4'd0)
            $display("FAIL reset_state: unlock=%b locked_out=%b fail_cnt=%0d, want 0/0/0",
                     unlock, locked_out, fail_cnt);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_correct();
        int n;
        send_bits(6'b111000, 5);
        total_cnt++;
        if (unlock !== 1'b0) $display("FAIL early_unlock: unlock=%b want 0", unlock);
        else pass_cnt++;
        // Sixth bit; unlock visible at the very next sample.
        @(negedge clk);
        bit_in = 1'b0; bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        total_cnt++;
        if (unlock !== 1'b1 || fail_cnt !== 4'd0 || locked_out !== 1'b0)
            $display("FAIL correct_open: unlock=%b fail_cnt=%0d locked_out=%b, want 1/0/0",
                     unlock, fail_cnt, locked_out);
        else pass_cnt++;
        count_unlock(n);
        total_cnt++;
        if (n !== 8) $display("FAIL unlock_len: got %0d cycles want 8", n);
        else pass_cnt++;
    endtask

    task automatic test_wrong();
        int n;
        send_bits(6'b011000, 5);
        total_cnt++;
        if (fail_cnt !== 4'd0) $display("FAIL early_verdict: fail_cnt=%0d want 0", fail_cnt);
        else pass_cnt++;
        send_bit(1'b0);
        total_cnt++;
        if (fail_cnt !== 4'd1 || unlock !== 1'b0 || locked_out !== 1'b0)
            $display("FAIL wrong_attempt: fail_cnt=%0d unlock=%b locked_out=%b, want 1/0/0",
                     fail_cnt, unlock, locked_out);
        else pass_cnt++;
        // idx must be back at 0: the correct code now opens and clears fail_cnt.
        send_bits(6'b111000, 6);
        total_cnt++;
        if (unlock !== 1'b1 || fail_cnt !== 4'd0)
            $display("FAIL after_wrong_open: unlock=%b fail_cnt=%0d, want 1/0", unlock, fail_cnt);
        else pass_cnt++;
        count_unlock(n);
    endtask

    task automatic test_lockout();
        logic [5:0] good;
        int n, bad;
        good = 6'b111000;
        send_bits(6'b000000, 6);
        send_bits(6'b101010, 6);
        total_cnt++;
        if (fail_cnt !== 4'd2 || locked_out !== 1'b0)
            $display("FAIL two_fails: fail_cnt=%0d locked_out=%b, want 2/0", fail_cnt, locked_out);
        else pass_cnt++;
        send_bits(6'b110000, 6);
        total_cnt++;
        if (locked_out !== 1'b1 || fail_cnt !== 4'd3 || unlock !== 1'b0)
            $display("FAIL lockout_enter: locked_out=%b fail_cnt=%0d unlock=%b, want 1/3/0",
                     locked_out, fail_cnt, unlock);
        else pass_cnt++;
        // Feed the correct code continuously while locked out; all of it is ignored.
        n = 0; bad = 0;
        while (locked_out === 1'b1 && n < 40) begin
            if (unlock !== 1'b0 || fail_cnt !== 4'd3) bad++;
            bit_in    = good[5 - (n % 6)];
            bit_valid = 1'b1;
            n++;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        total_cnt++;
        if (n !== 16) $display("FAIL lockout_len: got %0d cycles want 16", n);
        else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL lockout_hold: %0d bad cycles want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (fail_cnt !== 4'd0 || unlock !== 1'b0)
            $display("FAIL lockout_exit: fail_cnt=%0d unlock=%b, want 0/0", fail_cnt, unlock);
        else pass_cnt++;
        // Bits from lockout did not count: a fresh correct code opens.
        send_bits(6'b111000, 6);
        total_cnt++;
        if (unlock !== 1'b1) $display("FAIL post_lockout_open: unlock=%b want 1", unlock);
        else pass_cnt++;
        count_unlock(n);
    endtask

    task automatic test_gaps();
        int gaps [6] = '{0, 1, 2, 3, 0, 1};
        logic [5:0] c;
        int n;
        c = 6'b111000;
        for (int i = 0; i < 6; i++) begin
            repeat (gaps[i]) @(negedge clk);
            if (i == 5) begin
                total_cnt++;
                if (unlock !== 1'b0) $display("FAIL gap_early: unlock=%b want 0", unlock);
                else pass_cnt++;
            end
            send_bit(c[5-i]);
        end
        total_cnt++;
        if (unlock !== 1'b1) $display("FAIL gap_open: unlock=%b want 1", unlock);
        else pass_cnt++;
        count_unlock(n);
        total_cnt++;
        if (n !== 8) $display("FAIL gap_unlock_len: got %0d want 8", n);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        send_bits(6'b111000, 3);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        // Had the partial attempt survived, these 6 bits would be misaligned.
        send_bits(6'b111000, 6);
        total_cnt++;
        if (unlock !== 1'b1) $display("FAIL reset_partial: unlock=%b want 1", unlock);
        else pass_cnt++;
        // Reset while open must close immediately.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total_cnt++;
        if (unlock !== 1'b0 || fail_cnt !== 4'd0)
            $display("FAIL reset_open: unlock=%b fail_cnt=%0d, want 0/0", unlock, fail_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_prog();
        int n;
        // code_load in ENTRY is ignored in every build.
        code_in = 6'b000111; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        send_bits(6'b111000, 6);
        total_cnt++;
        if (unlock !== 1'b1) $display("FAIL prog_entry_ignored: unlock=%b want 1", unlock);
        else pass_cnt++;
        code_in = 6'b010101; code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        count_unlock(n);
        send_bits(6'b111000, 6);
`ifdef SERIAL_CODE_LOCK_PROG_EN
        total_cnt++;
        if (unlock !== 1'b0 || fail_cnt !== 4'd1)
            $display("FAIL prog_old_code: unlock=%b fail_cnt=%0d, want 0/1", unlock, fail_cnt);
        else pass_cnt++;
`else
        total_cnt++;
        if (unlock !== 1'b1 || fail_cnt !== 4'd0)
            $display("FAIL fixed_old_code: unlock=%b fail_cnt=%0d, want 1/0", unlock, fail_cnt);
        else pass_cnt++;
        count_unlock(n);
`endif
        send_bits(6'b010101, 6);
`ifdef SERIAL_CODE_LOCK_PROG_EN
        total_cnt++;
        if (unlock !== 1'b1 || fail_cnt !== 4'd0)
            $display("FAIL prog_new_code: unlock=%b fail_cnt=%0d, want 1/0", unlock, fail_cnt);
        else pass_cnt++;
        count_unlock(n);
`else
        total_cnt++;
        if (unlock !== 1'b0 || fail_cnt !== 4'd1)
            $display("FAIL fixed_new_code: unlock=%b fail_cnt=%0d, want 0/1", unlock, fail_cnt);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_correct();
        test_wrong();
        test_lockout();
        test_gaps();
        test_reset_mid();
        test_prog();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
